// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: sequencer states, register-zero index,
// and memctrl field positions used by the ID/EX stage.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MEMCTRL_RD = 0;
  localparam int unsigned MEMCTRL_WR = 1;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction in ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_lu_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match  = (i_ex_rt == i_id_rs);
  assign w_rt_match  = i_id_uses_rt && (i_ex_rt == i_id_rt);
  // Loads into $zero never create a real dependency.
  assign o_lu_hazard = i_ex_memread && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencer: load-use stall, branch squash, data-memory freeze with
// timeout, and a saturating stall-cycle counter.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_error
);

  localparam int unsigned WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : WCW'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_n;
  logic [WCW-1:0]   r_wcnt;
  logic [WCW-1:0]   w_wcnt_n;
  logic [CNT_W-1:0] r_stall_count;
  logic             r_mem_error;
  logic             w_err_set;
  logic             w_frozen;
  logic             w_timeout;
  logic             w_lu_hazard;

  load_use_detect u_lu (
    .i_ex_memread (ex_memread),
    .i_ex_rt      (ex_rt),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rt (id_uses_rt),
    .o_lu_hazard  (w_lu_hazard)
  );

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    w_state_n   = r_state;
    w_wcnt_n    = r_wcnt;
    w_err_set   = 1'b0;
    w_frozen    = 1'b0;
    w_timeout   = 1'b0;

    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      w_state_n   = RUN;
      w_wcnt_n    = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            w_frozen  = 1'b1;
            w_state_n = MEM_WAIT;
            w_wcnt_n  = '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            w_state_n = RUN;
          end else if (TIMEOUT != 0 && r_wcnt == TO_LAST) begin
            w_timeout = 1'b1;
            w_err_set = 1'b1;
            w_state_n = RUN;
          end else begin
            w_frozen = 1'b1;
            w_wcnt_n = r_wcnt + 1'b1;
          end
        end
        default: w_state_n = RUN;
      endcase

      if (w_frozen) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end else begin
        // A timed-out access is released but its stale result must not retire.
        memwb_flush = w_timeout;
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_lu_hazard) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= RUN;
      r_wcnt        <= '0;
      r_stall_count <= '0;
      r_mem_error   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_wcnt  <= w_wcnt_n;
      if (!pc_en && r_stall_count != '1) r_stall_count <= r_stall_count + 1'b1;
      if (w_err_set) r_mem_error <= 1'b1;
    end
  end

  assign stall_count = r_stall_count;
  assign mem_error   = r_mem_error;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (TIMEOUT=4, CNT_W=3) with an expected-value queue.
module tb_hazard_unit;

  localparam int unsigned CW = 3;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  localparam logic [6:0] C_DEF = 7'b1101010;
  localparam logic [6:0] C_RST = 7'b0010101;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_TO  = 7'b1101011;

  typedef struct packed {
    logic [6:0]    ctl;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
  logic [CW-1:0] stall_count;
  logic          mem_error;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  hazard_unit #(.TIMEOUT(4), .CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rt           (ex_rt),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .memwb_flush     (memwb_flush),
    .stall_count     (stall_count),
    .mem_error       (mem_error)
  );

  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] xrt, input logic mrd,
                       input logic br, input logic req, input logic rdy);
    @(negedge clock);
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rt = xrt;
    ex_memread = mrd; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  task automatic step(input string tag, input logic rst, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic [4:0] xrt,
                      input logic mrd, input logic br, input logic req, input logic rdy,
                      input logic [6:0] ectl, input logic [CW-1:0] ecnt, input logic eerr);
    exp_t e;
    logic [6:0] act;
    drive(rst, rs, rt, urt, xrt, mrd, br, req, rdy);
    q.push_back('{ctl: ectl, cnt: ecnt, err: eerr});
    #1;
    e = q.pop_front();
    act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};
    total++;
    assert (act === e.ctl) else begin
      bad++;
      $error("FAIL %s ctl got=%b exp=%b", tag, act, e.ctl);
    end
    total++;
    assert (stall_count === e.cnt) else begin
      bad++;
      $error("FAIL %s stall_count got=%0d exp=%0d", tag, stall_count, e.cnt);
    end
    total++;
    assert (mem_error === e.err) else begin
      bad++;
      $error("FAIL %s mem_error got=%b exp=%b", tag, mem_error, e.err);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
    step("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0);
    step("lu_rs",      0, 8, 0, 0, 8, 1, 0, 0, 0, C_LU,  0, 0);
    step("lu_clear",   0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 1, 0);
    step("lu_zero",    0, 0, 0, 0, 0, 1, 0, 0, 0, C_DEF, 1, 0);
    step("lu_rt",      0, 3, 9, 1, 9, 1, 0, 0, 0, C_LU,  1, 0);
    step("lu_rt_unused",0,3, 9, 0, 9, 1, 0, 0, 0, C_DEF, 2, 0);
    step("br_over_lu", 0, 8, 0, 0, 8, 1, 1, 0, 0, C_BR,  2, 0);
    step("br_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 2, 0);
    step("mem_same",   0, 0, 0, 0, 0, 0, 0, 1, 1, C_DEF, 2, 0);
    step("mem_w0",     0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 2, 0);
    step("mem_w1",     0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 3, 0);
    step("mem_w2_br",  0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 4, 0);
    step("mem_rel_br", 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR,  5, 0);
    step("mem_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 5, 0);
    step("reset2",     1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 5, 0);
    step("post_rst2",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0);
    step("to_w0",      0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0);
    step("to_w1",      0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0);
    step("to_w2",      0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 2, 0);
    step("to_w3",      0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 3, 0);
    step("to_fire",    0, 0, 0, 0, 0, 0, 0, 1, 0, C_TO,  4, 0);
    step("to_err",     0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 4, 1);
    step("to_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 4, 1);
    step("reset3",     1, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 4, 1);
    step("mw_a",       0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0);
    step("mw_b",       0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0);
    step("rst_midwait",1, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 2, 0);
    step("run_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0);
    for (int i = 0; i < 10; i++)
      step("sat", 0, 8, 0, 0, 8, 1, 0, 0, 0, C_LU, (i < 7) ? CW'(i) : 3'd7, 0);
    step("sat_end",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 7, 0);
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain size=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
